// File: rtl/m68k_bus_responder.sv
// 68010 asynchronous-bus slave: synchronises the CPU strobes, decodes fc/address and runs one
// req/ack backend transaction per bus cycle, terminating with DTACK, or with BERR on timeout.
module m68k_bus_responder #(
  parameter logic [22:0] DECODE_BASE = 23'h000000,
  parameter logic [22:0] DECODE_MASK = 23'h000000,
  parameter logic [7:0]  FC_ENABLE   = 8'b01101110,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        clk40,
  input  logic        reset_n,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        rw,
  input  logic [2:0]  fc,
  input  logic [22:0] addr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  output logic        d_oe,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        req,
  output logic        req_we,
  output logic [2:0]  req_fc,
  output logic [22:0] req_addr,
  output logic [1:0]  req_be,
  output logic [15:0] req_wdata,
  input  logic        ack,
  input  logic [15:0] rdata
);

  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, TERM, SKIP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  as_sync;
  logic [1:0]  uds_sync;
  logic [1:0]  lds_sync;
  logic        as_s;
  logic        uds_s;
  logic        lds_s;
  logic [7:0]  tmo_cnt;

  logic        fc_ok;
  logic        addr_ok;
  logic        strobe;
  logic        start;
  logic        miss;
  logic        tmo_last;

  logic        load_req;
  logic        end_ok;
  logic        end_err;
  logic        release_bus;

  // Two-flop synchronisers; reset to the negated (high) level.
  always_ff @(posedge clk40) begin
    if (!reset_n) begin
      as_sync  <= 2'b11;
      uds_sync <= 2'b11;
      lds_sync <= 2'b11;
    end else begin
      as_sync  <= {as_sync[0], as_n};
      uds_sync <= {uds_sync[0], uds_n};
      lds_sync <= {lds_sync[0], lds_n};
    end
  end

  assign as_s  = as_sync[1];
  assign uds_s = uds_sync[1];
  assign lds_s = lds_sync[1];

  // CPU space (fc=7) is excluded regardless of FC_ENABLE.
  assign fc_ok    = FC_ENABLE[fc] && (fc != 3'd7);
  assign addr_ok  = ((addr ^ DECODE_BASE) & DECODE_MASK) == 23'h000000;
  assign strobe   = !as_s && (!uds_s || !lds_s);
  assign start    = (state == IDLE) && strobe && fc_ok && addr_ok;
  assign miss     = (state == IDLE) && strobe && !(fc_ok && addr_ok);
  assign tmo_last = (tmo_cnt == 8'd1);

  always_ff @(posedge clk40) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start)     state_nxt = WAIT;
        else if (miss) state_nxt = SKIP;
      end
      WAIT: begin
        if (ack || tmo_last) state_nxt = TERM;
      end
      TERM: begin
        if (as_s) state_nxt = IDLE;
      end
      SKIP: begin
        if (as_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ack takes priority over the final timeout cycle.
  always_comb begin
    load_req    = 1'b0;
    end_ok      = 1'b0;
    end_err     = 1'b0;
    release_bus = 1'b0;
    unique case (state)
      IDLE: load_req = start;
      WAIT: begin
        if (ack)           end_ok  = 1'b1;
        else if (tmo_last) end_err = 1'b1;
      end
      TERM: release_bus = as_s;
      default: ;
    endcase
  end

  always_ff @(posedge clk40) begin
    if (!reset_n) begin
      tmo_cnt <= 8'd0;
    end else if (load_req) begin
      tmo_cnt <= TMO_LOAD;
    end else if (state == WAIT) begin
      if (tmo_cnt != 8'd0) tmo_cnt <= tmo_cnt - 8'd1;
    end else begin
      tmo_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk40) begin
    if (!reset_n) begin
      req       <= 1'b0;
      req_we    <= 1'b0;
      req_fc    <= 3'd0;
      req_addr  <= 23'h000000;
      req_be    <= 2'b00;
      req_wdata <= 16'h0000;
      d_out     <= 16'h0000;
      d_oe      <= 1'b0;
      dtack_n   <= 1'b1;
      berr_n    <= 1'b1;
    end else begin
      if (load_req) begin
        req       <= 1'b1;
        req_we    <= ~rw;
        req_fc    <= fc;
        req_addr  <= addr;
        req_be    <= {~uds_s, ~lds_s};
        req_wdata <= d_in;
      end
      if (end_ok) begin
        req     <= 1'b0;
        dtack_n <= 1'b0;
        if (!req_we) begin
          d_out <= rdata;
          d_oe  <= 1'b1;
        end
      end
      if (end_err) begin
        req    <= 1'b0;
        berr_n <= 1'b0;
      end
      // d_out is deliberately left holding the last read value.
      if (release_bus) begin
        dtack_n <= 1'b1;
        berr_n  <= 1'b1;
        d_oe    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Bench for m68k_bus_responder: instance a (open decode, TIMEOUT=8) runs a vector table,
// instance b (masked decode, all FCs enabled, TIMEOUT=4) covers decode miss, CPU space and timeout edges.
module tb_m68k_bus_responder;

  logic        clk40 = 1'b0;
  logic        reset_n = 1'b0;
  logic        as_n = 1'b1;
  logic        uds_n = 1'b1;
  logic        lds_n = 1'b1;
  logic        rw = 1'b1;
  logic [2:0]  fc = 3'd0;
  logic [22:0] addr = 23'h0;
  logic [15:0] d_in = 16'h0;

  logic [15:0] a_d_out, b_d_out;
  logic        a_d_oe, b_d_oe, a_dtack_n, b_dtack_n, a_berr_n, b_berr_n;
  logic        a_req, b_req, a_req_we, b_req_we;
  logic [2:0]  a_req_fc, b_req_fc;
  logic [22:0] a_req_addr, b_req_addr;
  logic [1:0]  a_req_be, b_req_be;
  logic [15:0] a_req_wdata, b_req_wdata;
  logic        a_ack = 1'b0, b_ack = 1'b0;
  logic [15:0] a_rdata = 16'h0, b_rdata = 16'h0;

  always #12.5 clk40 = ~clk40;

  m68k_bus_responder #(.DECODE_BASE(23'h0), .DECODE_MASK(23'h0),
                       .FC_ENABLE(8'b01101110), .TIMEOUT(8)) u_a (
    .clk40(clk40), .reset_n(reset_n), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .rw(rw), .fc(fc), .addr(addr), .d_in(d_in), .d_out(a_d_out), .d_oe(a_d_oe),
    .dtack_n(a_dtack_n), .berr_n(a_berr_n), .req(a_req), .req_we(a_req_we),
    .req_fc(a_req_fc), .req_addr(a_req_addr), .req_be(a_req_be),
    .req_wdata(a_req_wdata), .ack(a_ack), .rdata(a_rdata));

  m68k_bus_responder #(.DECODE_BASE(23'h0), .DECODE_MASK(23'h7FF800),
                       .FC_ENABLE(8'hFF), .TIMEOUT(4)) u_b (
    .clk40(clk40), .reset_n(reset_n), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .rw(rw), .fc(fc), .addr(addr), .d_in(d_in), .d_out(b_d_out), .d_oe(b_d_oe),
    .dtack_n(b_dtack_n), .berr_n(b_berr_n), .req(b_req), .req_we(b_req_we),
    .req_fc(b_req_fc), .req_addr(b_req_addr), .req_be(b_req_be),
    .req_wdata(b_req_wdata), .ack(b_ack), .rdata(b_rdata));

  // Backend models: ack after 'delay' req cycles, with running activity counters.
  logic        a_ack_en = 1'b0, b_ack_en = 1'b0;
  int          a_delay = 0, b_delay = 0;
  logic [15:0] a_rd_val = 16'h0, b_rd_val = 16'h0;
  int          a_cur = 0, b_cur = 0, a_tot = 0, b_tot = 0, a_pulses = 0, b_pulses = 0;
  int          b_dtack_cyc = 0, b_berr_cyc = 0;
  logic        a_req_q = 1'b0, b_req_q = 1'b0;

  always @(posedge clk40) begin
    #1;
    if (a_req) begin
      if (!a_req_q) a_pulses++;
      a_ack   = a_ack_en && (a_cur == a_delay);
      a_rdata = a_ack ? a_rd_val : 16'h0;
      a_cur++;
      a_tot++;
    end else begin
      a_ack   = 1'b0;
      a_rdata = 16'h0;
      a_cur   = 0;
    end
    a_req_q = a_req;
    if (b_req) begin
      if (!b_req_q) b_pulses++;
      b_ack   = b_ack_en && (b_cur == b_delay);
      b_rdata = b_ack ? b_rd_val : 16'h0;
      b_cur++;
      b_tot++;
    end else begin
      b_ack   = 1'b0;
      b_rdata = 16'h0;
      b_cur   = 0;
    end
    b_req_q = b_req;
    if (!b_dtack_n) b_dtack_cyc++;
    if (!b_berr_n)  b_berr_cyc++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  fc;
    logic [22:0] addr;
    logic        rw, uds, lds;
    logic [15:0] din;
    logic        ack_en;
    int          delay;
    logic [15:0] rdata;
    int          exp_term;  // 0 none, 1 dtack, 2 berr
    logic        exp_we;
    logic [1:0]  exp_be;
    logic [15:0] exp_wdata, exp_dout;
    logic        exp_doe;
    int          exp_rcyc;
    logic [2:0]  exp_fc;
    logic [22:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic release_strobes();
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
  endtask

  task automatic b_cycle(input logic [2:0] f, input logic [22:0] ad, input logic en,
                         input int dly, input logic [15:0] rd, output int pulses,
                         output int dcyc, output int bcyc, output int rcyc);
    int p0, d0, e0, t0;
    b_ack_en = en; b_delay = dly; b_rd_val = rd;
    p0 = b_pulses; d0 = b_dtack_cyc; e0 = b_berr_cyc; t0 = b_tot;
    @(negedge clk40);
    fc = f; addr = ad; rw = 1'b1; d_in = 16'h0;
    @(negedge clk40);
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    repeat (16) @(negedge clk40);
    release_strobes();
    repeat (5) @(negedge clk40);
    pulses = b_pulses - p0;
    dcyc   = b_dtack_cyc - d0;
    bcyc   = b_berr_cyc - e0;
    rcyc   = b_tot - t0;
  endtask

  initial begin
    int term, p0, t0, lat, pulses, dcyc, bcyc, rcyc;
    logic seen;

    vecs[0] = '{3'd5, 23'h000800, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'hBEEF,
                1, 1'b0, 2'b11, 16'h0000, 16'hBEEF, 1'b1, 2, 3'd5, 23'h000800};
    vecs[1] = '{3'd5, 23'h000C00, 1'b0, 1'b1, 1'b0, 16'h0034, 1'b1, 0, 16'h0000,
                1, 1'b1, 2'b01, 16'h0034, 16'hBEEF, 1'b0, 1, 3'd5, 23'h000C00};
    vecs[2] = '{3'd1, 23'h123456, 1'b1, 1'b0, 1'b1, 16'h1111, 1'b1, 2, 16'h5A00,
                1, 1'b0, 2'b10, 16'h1111, 16'h5A00, 1'b1, 3, 3'd1, 23'h123456};
    vecs[3] = '{3'd2, 23'h000800, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 16'h0000,
                2, 1'b0, 2'b11, 16'h0000, 16'h5A00, 1'b0, 8, 3'd2, 23'h000800};
    vecs[4] = '{3'd6, 23'h7FFFFF, 1'b0, 1'b0, 1'b0, 16'hA5C3, 1'b1, 3, 16'h0000,
                1, 1'b1, 2'b11, 16'hA5C3, 16'h5A00, 1'b0, 4, 3'd6, 23'h7FFFFF};
    vecs[5] = '{3'd3, 23'h000001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 7, 16'h1234,
                1, 1'b0, 2'b11, 16'h0000, 16'h1234, 1'b1, 8, 3'd3, 23'h000001};
    vecs[6] = '{3'd4, 23'h000800, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 16'h0000,
                0, 1'b0, 2'b11, 16'h0000, 16'h1234, 1'b0, 0, 3'd3, 23'h000001};
    vecs[7] = '{3'd0, 23'h000800, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 0, 16'h0000,
                0, 1'b0, 2'b11, 16'h0000, 16'h1234, 1'b0, 0, 3'd3, 23'h000001};

    repeat (3) @(negedge clk40);
    chk("rst_dtack", a_dtack_n, 1);
    chk("rst_berr", a_berr_n, 1);
    chk("rst_doe", a_d_oe, 0);
    chk("rst_dout", a_d_out, 0);
    chk("rst_req", a_req, 0);
    chk("rst_b_dtack", b_dtack_n, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk40);

    for (int i = 0; i < 8; i++) begin
      a_ack_en = vecs[i].ack_en; a_delay = vecs[i].delay; a_rd_val = vecs[i].rdata;
      p0 = a_pulses; t0 = a_tot;
      @(negedge clk40);
      fc = vecs[i].fc; addr = vecs[i].addr; rw = vecs[i].rw; d_in = vecs[i].din;
      @(negedge clk40);
      as_n = 1'b0; uds_n = vecs[i].uds; lds_n = vecs[i].lds;
      term = 0;
      for (int k = 0; k < 24; k++) begin
        @(negedge clk40);
        if (!a_dtack_n) begin term = 1; break; end
        if (!a_berr_n)  begin term = 2; break; end
      end
      chk($sformatf("v%0d_term", i), term, vecs[i].exp_term);
      chk($sformatf("v%0d_we", i), a_req_we, vecs[i].exp_we);
      chk($sformatf("v%0d_be", i), a_req_be, vecs[i].exp_be);
      chk($sformatf("v%0d_wdata", i), a_req_wdata, vecs[i].exp_wdata);
      chk($sformatf("v%0d_fc", i), a_req_fc, vecs[i].exp_fc);
      chk($sformatf("v%0d_addr", i), a_req_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_dout", i), a_d_out, vecs[i].exp_dout);
      chk($sformatf("v%0d_doe", i), a_d_oe, vecs[i].exp_doe);
      chk($sformatf("v%0d_req_low", i), a_req, 0);
      chk($sformatf("v%0d_req_cycles", i), a_tot - t0, vecs[i].exp_rcyc);
      release_strobes();
      repeat (5) @(negedge clk40);
      chk($sformatf("v%0d_pulses", i), a_pulses - p0, (vecs[i].exp_term != 0) ? 1 : 0);
      chk($sformatf("v%0d_rel_dtack", i), a_dtack_n, 1);
      chk($sformatf("v%0d_rel_berr", i), a_berr_n, 1);
      chk($sformatf("v%0d_rel_doe", i), a_d_oe, 0);
    end

    // Reset while the backend is being waited on.
    a_ack_en = 1'b0;
    @(negedge clk40);
    fc = 3'd5; addr = 23'h000800; rw = 1'b1;
    @(negedge clk40);
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk40);
      if (a_req) begin seen = 1'b1; break; end
    end
    chk("mid_req_seen", seen, 1);
    repeat (2) @(negedge clk40);
    reset_n = 1'b0;
    release_strobes();
    @(negedge clk40);
    chk("mid_rst_req", a_req, 0);
    chk("mid_rst_dout", a_d_out, 0);
    chk("mid_rst_be", a_req_be, 0);
    chk("mid_rst_addr", a_req_addr, 0);
    chk("mid_rst_fc", a_req_fc, 0);
    chk("mid_rst_dtack", a_dtack_n, 1);
    chk("mid_rst_berr", a_berr_n, 1);
    reset_n = 1'b1;
    repeat (3) @(negedge clk40);

    a_ack_en = 1'b1; a_delay = 0; a_rd_val = 16'hC0DE;
    fc = 3'd5; addr = 23'h000800; rw = 1'b1;
    @(negedge clk40);
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk40);
      if (!a_dtack_n) begin lat = k; break; end
    end
    chk("latency", lat, 4);
    chk("lat_dout", a_d_out, 16'hC0DE);
    release_strobes();
    repeat (5) @(negedge clk40);

    // Instance b: masked decode, CPU space, ack on last cycle, one cycle too late.
    a_ack_en = 1'b1; a_delay = 0; a_rd_val = 16'h0;
    b_cycle(3'd5, 23'h001000, 1'b1, 0, 16'h0000, pulses, dcyc, bcyc, rcyc);
    chk("miss_pulses", pulses, 0);
    chk("miss_dtack", dcyc, 0);
    chk("miss_berr", bcyc, 0);
    b_cycle(3'd7, 23'h000000, 1'b1, 0, 16'h0000, pulses, dcyc, bcyc, rcyc);
    chk("cpusp_pulses", pulses, 0);
    chk("cpusp_dtack", dcyc, 0);
    chk("cpusp_berr", bcyc, 0);
    b_cycle(3'd5, 23'h000000, 1'b1, 3, 16'h0F0F, pulses, dcyc, bcyc, rcyc);
    chk("coinc_pulses", pulses, 1);
    chk("coinc_dtack", (dcyc > 0) ? 1 : 0, 1);
    chk("coinc_berr", bcyc, 0);
    chk("coinc_rcyc", rcyc, 4);
    chk("coinc_dout", b_d_out, 16'h0F0F);
    b_cycle(3'd5, 23'h000000, 1'b1, 4, 16'h7777, pulses, dcyc, bcyc, rcyc);
    chk("late_pulses", pulses, 1);
    chk("late_dtack", dcyc, 0);
    chk("late_berr", (bcyc > 0) ? 1 : 0, 1);
    chk("late_rcyc", rcyc, 4);
    chk("late_dout", b_d_out, 16'h0F0F);
    chk("late_rel_berr", b_berr_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- Slave-side responder for the 68010 asynchronous bus, the counterpart of the CPU bus-functional model driven by the top-level bench.
- Synchronises AS/UDS/LDS from the CPU side and decodes matching cycles by function code and address.
- Hands each matching cycle to a synchronous backend as a single request/acknowledge transaction, then terminates the bus cycle with DTACK, or with BERR on timeout.
- Sits between the CPU bus pins and the MMU, I/O, or RAM backends.

Parameters:
- DECODE_BASE, 23'h000000: address bits [23:1] that must match for the block to respond.
- DECODE_MASK, 23'h000000: 1 bits of the mask take part in the address compare; all zeros matches every address.
- FC_ENABLE, 8'b01101110: bit n set means function code n is accepted; FC=7 (CPU space) is never accepted, whatever this parameter says.
- TIMEOUT, 64: clk40 cycles to wait for ack before terminating with BERR; legal range 2..255.

Ports:
- clk40, input, 1: sole clock; all state updates on the rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- as_n, input, 1: address strobe, asynchronous to clk40.
- uds_n, input, 1: upper data strobe, asynchronous.
- lds_n, input, 1: lower data strobe, asynchronous.
- rw, input, 1: 1 = read, 0 = write.
- fc, input, 3: function code.
- addr, input, 23: CPU address bits [23:1].
- d_in, input, 16: CPU write data.
- d_out, output, 16: read data driven toward the CPU.
- d_oe, output, 1: enable for the read-data driver.
- dtack_n, output, 1: data transfer acknowledge, active-low.
- berr_n, output, 1: bus error, active-low.
- req, output, 1: backend request.
- req_we, output, 1: backend write enable.
- req_fc, output, 3: latched function code.
- req_addr, output, 23: latched address.
- req_be, output, 2: byte enables; [1] = upper byte, [0] = lower byte.
- req_wdata, output, 16: latched write data.
- ack, input, 1: backend acknowledge.
- rdata, input, 16: backend read data, valid while ack is high.

Behaviour:
- Reset (reset_n low at a clk40 edge): state IDLE. dtack_n=1, berr_n=1, d_oe=0, d_out=0, req=0, req_we=0, req_be=0, req_fc=0, req_addr=0, req_wdata=0. Synchroniser flops are set to 1 (strobes negated). Timeout counter is cleared.
- Reset mid-cycle: outputs go to reset values on the next edge. The bus cycle in progress is abandoned with no DTACK; the CPU side sees it time out externally.
- Synchroniser: as_n, uds_n and lds_n each pass through 2 flops, giving as_s, uds_s, lds_s. rw, fc, addr and d_in are not synchronised; they are sampled only when the synchronised strobes say they are stable.
- Start condition (IDLE): as_s=0, (uds_s=0 or lds_s=0), fc accepted, and (addr & DECODE_MASK) == (DECODE_BASE & DECODE_MASK).
  - A write whose data strobes are not yet low waits in IDLE; it is not rejected.
  - A non-matching cycle goes to state SKIP and produces no outputs.
- States:
  - IDLE: when the start condition holds, latch req_addr=addr, req_fc=fc, req_we=~rw, req_be={~uds_s,~lds_s}, req_wdata=d_in; assert req; load the timeout counter with TIMEOUT; go to WAIT.
  - WAIT: req held high. The counter decrements each cycle.
    - ack=1: req goes low next cycle; if it was a read, d_out is latched from rdata and d_oe=1; dtack_n=0; go to TERM.
    - ack in the same cycle the counter reaches 0: ack wins.
    - Counter reaches 0 with ack=0: req goes low, berr_n=0, go to TERM.
  - TERM: dtack_n (or berr_n) and d_out/d_oe are held until as_s=1. On that edge dtack_n=1, berr_n=1, d_oe=0, and the state returns to IDLE. d_out keeps its value.
  - SKIP: wait for as_s=1, then go to IDLE.
- Latency, measured in clk40 edges from as_n/ds falling to dtack_n low, with ack on the first req cycle: 2 (sync) + 1 (req) + 1 (dtack) = 4.
- ack is sampled only in WAIT; an ack seen in any other state is ignored.
- Exactly one req high period is issued per bus cycle. req never re-asserts until as_s has been observed high.
- Write-data capture: d_in is latched on the start edge. The CPU holds data before DS asserts, so the 2-flop delay guarantees d_in is stable at that point.

Test Plan:
- Read match: DECODE_MASK=0, fc=5, addr=24'h001000 (addr[23:1]=23'h000800), rw=1, both DS low; backend acks 1 cycle after req with rdata=16'hBEEF -> req_addr=23'h000800, req_be=2'b11, req_we=0; d_out=16'hBEEF, d_oe=1, dtack_n=0 until as_n rises; exactly one req high period.
- Byte write: fc=5, addr=24'h001800, rw=0, uds_n=1, lds_n=0, d_in=16'h0034 -> req_we=1, req_be=2'b01, req_wdata=16'h0034, dtack_n=0, d_oe stays 0.
- Timeout: TIMEOUT=8, ack tied low -> berr_n=0 after 8 WAIT cycles, dtack_n stays 1, req drops; on as_n rise, berr_n=1 and state returns to IDLE.
- Decode miss and CPU space: DECODE_MASK=23'h7FF800, DECODE_BASE=0, addr=24'h002000 -> no req, no dtack. A second cycle with fc=7 and a matching address -> also no response.
- Ack coincident with timeout expiry (TIMEOUT=4, ack on the 4th WAIT cycle) -> dtack_n=0 and berr_n stays 1.
- Reset mid-WAIT: reset_n low for 1 edge -> all outputs return to reset values; a subsequent normal read completes with latency 4.
